// File: rtl/rx_pkt_assembler.sv
// rx_pkt_assembler: collects a framed byte stream into one wide packet register
// and presents it on a valid/ready packet port with byte count and overflow flag.
module rx_pkt_assembler #(
    parameter int P_PKT_BITS = 1500*8
) (
    input  logic                  rx_clk,
    input  logic                  rx_rst_n,
    input  logic                  rx_byte_vld,
    output logic                  rx_byte_rdy,
    input  logic [7:0]            rx_byte,
    input  logic                  rx_byte_last,
    output logic                  pkt_vld,
    input  logic                  pkt_rdy,
    output logic [P_PKT_BITS-1:0] pkt,
    output logic [10:0]           pkt_bytes,
    output logic                  pkt_err
);
    localparam int CAP = P_PKT_BITS / 8;
    localparam logic [10:0] C = 11'(CAP);

    typedef enum logic {S_FILL, S_HOLD} state_t;
    state_t state, state_nxt;

    logic [10:0] cnt;
    logic        ovf;
    logic        full;
    logic        byte_xfer;
    logic        pkt_xfer;

    // handshakes are decoded from the state register only
    assign byte_xfer = rx_byte_vld & (state == S_FILL);
    assign pkt_xfer  = pkt_rdy & (state == S_HOLD);
    assign full      = cnt == C;

    always_ff @(posedge rx_clk or negedge rx_rst_n)
        if (!rx_rst_n) state <= S_FILL;
        else state <= state_nxt;

    always_comb begin
        rx_byte_rdy = state == S_FILL;
        pkt_vld     = state == S_HOLD;
        state_nxt   = (byte_xfer & rx_byte_last) ? S_HOLD : pkt_xfer ? S_FILL : state;
    end

    always_ff @(posedge rx_clk or negedge rx_rst_n)
        if (!rx_rst_n) begin
            cnt       <= '0;
            ovf       <= 1'b0;
            pkt_bytes <= '0;
            pkt_err   <= 1'b0;
        end else if (pkt_xfer) begin
            cnt <= '0;
            ovf <= 1'b0;
        end else if (byte_xfer) begin
            cnt <= full ? cnt : cnt + 11'd1;
            ovf <= ovf | full;
            if (rx_byte_last) begin
                pkt_bytes <= full ? C : cnt + 11'd1;
                pkt_err   <= ovf | full;
            end
        end

    // bytes past capacity are dropped, so unused bytes of pkt stay zero
    always_ff @(posedge rx_clk or negedge rx_rst_n)
        if (!rx_rst_n) pkt <= '0;
        else if (pkt_xfer) pkt <= '0;
        else if (byte_xfer && !full)
            for (int k = 0; k < CAP; k++)
                if (cnt == 11'(k)) pkt[8*k +: 8] <= rx_byte;
endmodule

// File: tb/tb_rx_pkt_assembler.sv
// tb_rx_pkt_assembler: drives a full-size and a 64-bit assembler from one byte stream
// and compares every delivered packet against a scoreboard of expected packets.
module tb_rx_pkt_assembler;
    localparam int BB = 1500*8;
    localparam int SB = 64;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic byte_vld = 1'b0;
    logic byte_last = 1'b0;
    logic pkt_rdy = 1'b0;
    logic [7:0] rx_byte = 8'h00;

    logic rdy_b, vld_b, err_b, rdy_s, vld_s, err_s;
    logic [BB-1:0] pkt_b;
    logic [SB-1:0] pkt_s;
    logic [10:0] bytes_b, bytes_s;

    always #5 clk = ~clk;

    rx_pkt_assembler #(.P_PKT_BITS(BB)) dut_b (
        .rx_clk(clk), .rx_rst_n(rst_n), .rx_byte_vld(byte_vld), .rx_byte_rdy(rdy_b),
        .rx_byte(rx_byte), .rx_byte_last(byte_last), .pkt_vld(vld_b), .pkt_rdy(pkt_rdy),
        .pkt(pkt_b), .pkt_bytes(bytes_b), .pkt_err(err_b));

    rx_pkt_assembler #(.P_PKT_BITS(SB)) dut_s (
        .rx_clk(clk), .rx_rst_n(rst_n), .rx_byte_vld(byte_vld), .rx_byte_rdy(rdy_s),
        .rx_byte(rx_byte), .rx_byte_last(byte_last), .pkt_vld(vld_s), .pkt_rdy(pkt_rdy),
        .pkt(pkt_s), .pkt_bytes(bytes_s), .pkt_err(err_s));

    typedef struct {
        logic [BB-1:0] data;
        logic [10:0]   n;
        logic          err;
    } exp_t;

    typedef struct {
        int         len;
        logic [7:0] first;
        logic [7:0] step;
        bit         gaps;
        logic [10:0] exp_n_s;
        logic        exp_err_s;
    } vec_t;

    exp_t q_b[$];
    exp_t q_s[$];
    exp_t e_b, e_s;
    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [BB-1:0] act, input logic [BB-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h want %0h (low 128 bits)", name, act[127:0], exp[127:0]);
        end
    endtask

    function automatic exp_t model(input logic [7:0] b[$], input int cap);
        exp_t e;
        e.data = '0;
        e.err  = 1'b0;
        foreach (b[i])
            if (i < cap) e.data[8*i +: 8] = b[i];
            else e.err = 1'b1;
        e.n = 11'((b.size() > cap) ? cap : b.size());
        return e;
    endfunction

    task automatic xfer_byte(input logic [7:0] v, input bit last, input bit gaps, inout int cyc);
        bit ok = 1'b0;
        if (gaps)
            while ($urandom_range(0, 1) == 1) begin
                byte_vld = 1'b0;
                @(posedge clk); #1;
                cyc++;
            end
        byte_vld  = 1'b1;
        rx_byte   = v;
        byte_last = last;
        for (int t = 0; t < 200; t++) begin
            ok = rdy_b;
            @(posedge clk); #1;
            cyc++;
            if (ok) break;
        end
        if (!ok) begin
            tests++;
            fails++;
            $display("FAIL byte_timeout: byte %0h never accepted within 200 cycles", v);
        end
    endtask

    task automatic send(input logic [7:0] b[$], input bit gaps, output int cyc);
        int c = 0;
        q_b.push_back(model(b, BB/8));
        q_s.push_back(model(b, SB/8));
        foreach (b[i]) xfer_byte(b[i], i == b.size() - 1, gaps, c);
        byte_vld  = 1'b0;
        byte_last = 1'b0;
        cyc = c;
    endtask

    always @(negedge clk) begin
        if (rst_n && vld_b && pkt_rdy) begin
            if (q_b.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL big_unexpected: packet delivered with %0d bytes, none expected", bytes_b);
            end else begin
                e_b = q_b.pop_front();
                check("big_pkt", pkt_b, e_b.data);
                check("big_bytes", BB'(bytes_b), BB'(e_b.n));
                check("big_err", BB'(err_b), BB'(e_b.err));
            end
        end
        if (rst_n && vld_s && pkt_rdy) begin
            if (q_s.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL small_unexpected: packet delivered with %0d bytes, none expected", bytes_s);
            end else begin
                e_s = q_s.pop_front();
                check("small_pkt", BB'(pkt_s), e_s.data);
                check("small_bytes", BB'(bytes_s), BB'(e_s.n));
                check("small_err", BB'(err_s), BB'(e_s.err));
            end
        end
    end

    initial begin
        vec_t vecs[8];
        logic [7:0] b[$];
        int cyc;
        vecs[0] = '{4,  8'h11, 8'h11, 1'b0, 11'd4, 1'b0};
        vecs[1] = '{1,  8'hA5, 8'h00, 1'b0, 11'd1, 1'b0};
        vecs[2] = '{2,  8'h01, 8'h01, 1'b0, 11'd2, 1'b0};
        vecs[3] = '{10, 8'h00, 8'h01, 1'b0, 11'd8, 1'b1};
        vecs[4] = '{2,  8'h20, 8'h01, 1'b0, 11'd2, 1'b0};
        vecs[5] = '{6,  8'h30, 8'h01, 1'b1, 11'd6, 1'b0};
        vecs[6] = '{8,  8'h40, 8'h01, 1'b0, 11'd8, 1'b0};
        vecs[7] = '{9,  8'h50, 8'h01, 1'b0, 11'd8, 1'b1};

        repeat (2) @(posedge clk);
        #1;
        check("reset_vld", BB'(vld_b), BB'(1'b0));
        check("reset_pkt", pkt_b, '0);
        check("reset_bytes", BB'(bytes_b), '0);
        check("reset_err", BB'(err_s), '0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("reset_rdy", BB'(rdy_b), BB'(1'b1));

        pkt_rdy = 1'b1;
        foreach (vecs[v]) begin
            b.delete();
            for (int i = 0; i < vecs[v].len; i++) b.push_back(8'(vecs[v].first + 8'(i) * vecs[v].step));
            send(b, vecs[v].gaps, cyc);
            check($sformatf("vec%0d_vld_hi", v), BB'(vld_b), BB'(1'b1));
            check($sformatf("vec%0d_rdy_lo", v), BB'(rdy_b), BB'(1'b0));
            check($sformatf("vec%0d_bytes_s", v), BB'(bytes_s), BB'(vecs[v].exp_n_s));
            check($sformatf("vec%0d_err_s", v), BB'(err_s), BB'(vecs[v].exp_err_s));
            if (!vecs[v].gaps) check($sformatf("vec%0d_rate", v), BB'(cyc), BB'(vecs[v].len));
            @(posedge clk); #1;
            check($sformatf("vec%0d_vld_lo", v), BB'(vld_b), BB'(1'b0));
            check($sformatf("vec%0d_rdy_hi", v), BB'(rdy_b), BB'(1'b1));
        end

        pkt_rdy = 1'b0;
        b = '{8'h61, 8'h62, 8'h63};
        send(b, 1'b0, cyc);
        byte_vld = 1'b1;
        rx_byte  = 8'hB0;
        repeat (5) begin
            check("bp_rdy_lo", BB'(rdy_b), BB'(1'b0));
            check("bp_vld_hi", BB'(vld_b), BB'(1'b1));
            check("bp_pkt_stable", BB'(pkt_b[23:0]), BB'(24'h636261));
            check("bp_bytes_stable", BB'(bytes_s), BB'(11'd3));
            @(posedge clk); #1;
        end
        pkt_rdy = 1'b1;
        @(posedge clk); #1;
        check("bp_release_rdy", BB'(rdy_b), BB'(1'b1));
        check("bp_release_vld", BB'(vld_b), BB'(1'b0));
        b = '{8'hB0, 8'hB1, 8'hB2};
        send(b, 1'b0, cyc);
        check("bp_second_rate", BB'(cyc), BB'(3));
        @(posedge clk); #1;

        cyc = 0;
        for (int i = 0; i < 3; i++) xfer_byte(8'hC1 + 8'(i), 1'b0, 1'b0, cyc);
        byte_vld = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("arst_pkt", pkt_b, '0);
        check("arst_pkt_s", BB'(pkt_s), '0);
        check("arst_bytes", BB'(bytes_b), '0);
        check("arst_vld", BB'(vld_b), BB'(1'b0));
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (3) begin
            check("arst_no_vld", BB'(vld_b), BB'(1'b0));
            @(posedge clk); #1;
        end
        b = '{8'h7E, 8'h7F};
        send(b, 1'b0, cyc);
        check("arst_next_bytes", BB'(bytes_b), BB'(11'd2));
        @(posedge clk); #1;

        check("scoreboard_big_empty", BB'(q_b.size()), '0);
        check("scoreboard_small_empty", BB'(q_s.size()), '0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/rx_pkt_assembler.md
# rx_pkt_assembler

Byte-stream to packet assembler for the network stack receive path. It consumes a framed byte stream (valid/ready plus last) and collects the bytes into one wide packet register. It then presents that register on a valid/ready packet interface with a byte count and an error flag. It is the inverse of the packet-to-byte serializer: its packet output has the layout the serializer consumes (first byte in bits [7:0]), so the two can be chained for loopback.

## Interface
- P_PKT_BITS, 1500*8: packet register width in bits; capacity C = P_PKT_BITS/8 bytes; must be a multiple of 8.
- rx_clk  in  1  sole clock; all logic on its rising edge.
- rx_rst_n  in  1  asynchronous, active-low reset; one clock; reset is asynchronous and active-low.
- rx_byte_vld  in  1  input byte valid.
- rx_byte_rdy  out  1  assembler can accept a byte.
- rx_byte  in  8  input byte.
- rx_byte_last  in  1  qualifies rx_byte as the final byte of a packet.
- pkt_vld  out  1  assembled packet available.
- pkt_rdy  in  1  downstream accepts the packet.
- pkt  out  P_PKT_BITS  assembled packet; byte k in bits [8k+7:8k].
- pkt_bytes  out  11  number of valid bytes in pkt, range 1..C.
- pkt_err  out  1  packet overflowed capacity; excess bytes dropped.

## Operation
- Byte transfer occurs on a cycle with rx_byte_vld & rx_byte_rdy. Packet transfer occurs on a cycle with pkt_vld & pkt_rdy.
- Two states:
  - S_FILL: rx_byte_rdy=1, pkt_vld=0.
  - S_HOLD: rx_byte_rdy=0, pkt_vld=1.
- Both outputs decode from the state register only. There is no combinational path from inputs to handshake outputs.
- Reset (asynchronous assert) drives:
  - state=S_FILL, byte count=0
  - pkt=0, pkt_bytes=0, pkt_err=0
  - rx_byte_rdy=1 after release, pkt_vld=0
  - A packet partially collected when reset asserts is discarded; no pkt_vld is produced for it.
- S_FILL, on each byte transfer:
  - If cnt < C: write rx_byte to pkt[8·cnt+7:8·cnt], then cnt <= cnt+1.
  - If cnt == C: discard the byte, hold cnt, set the overflow flag.
  - If rx_byte_last=1: go to S_HOLD, with pkt_bytes <= count including this byte (saturated at C) and pkt_err <= overflow flag (including overflow caused by this byte).
- S_HOLD:
  - pkt, pkt_bytes and pkt_err are stable for the whole state.
  - On packet transfer go to S_FILL, clear pkt to 0, clear cnt and the overflow flag.
  - pkt_bytes and pkt_err hold their values until the next packet completes.
- Bits of pkt above byte pkt_bytes-1 always read 0.
- rx_byte_vld without a transfer (rdy=0) is ignored. The upstream holds the byte.
- Zero-length packets do not exist: the last flag always accompanies a data byte.
- Byte count arithmetic is 11 bits unsigned. C ≤ 2047 is required.

## Timing
- Byte transfer with last at edge N: pkt_vld=1 from cycle N+1.
- Packet transfer at edge M: rx_byte_rdy=1 from cycle M+1, and the first byte of the next packet can transfer at edge M+1.
- Minimum packet period: n+1 cycles for an n-byte packet with pkt_rdy held high, giving one cycle where rx_byte_rdy=0.
- Sustained byte rate in S_FILL: 1 byte per cycle.
- pkt_rdy held high before pkt_vld rises: the packet transfers in the first S_HOLD cycle.
- pkt_rdy low: S_HOLD is held indefinitely. Input backpressure via rx_byte_rdy=0 loses no bytes.

## Test plan
- Reset then 4 bytes 0x11,0x22,0x33,0x44 (last on 0x44), pkt_rdy=1:
  - pkt[31:0]=0x44332211, pkt_bytes=4, pkt_err=0, rest of pkt 0
  - pkt_vld high exactly one cycle, rx_byte_rdy low exactly one cycle
- Single byte 0xA5 with last=1:
  - pkt[7:0]=0xA5, pkt_bytes=1
  - then 2 bytes 0x01,0x02: pkt[15:0]=0x0201, pkt[23:8]... bits above 15 = 0 (no residue from the first packet)
- Back-to-back 3-byte packets with pkt_rdy=0 for 5 cycles after the first completes:
  - rx_byte_rdy=0 throughout, first packet stable
  - second packet's bytes accepted starting one cycle after the pkt_rdy transfer
- With P_PKT_BITS=64, send 10 bytes 0..9:
  - pkt=0x0706050403020100, pkt_bytes=8, pkt_err=1
  - next 2-byte packet has pkt_err=0
- Random rx_byte_vld gaps (50%) on a 6-byte packet: bytes assembled in order, pkt_bytes=6.
- Assert rx_rst_n low asynchronously after 3 of 5 bytes:
  - outputs clear immediately, no pkt_vld
  - next full 2-byte packet assembles correctly with pkt_bytes=2
